// File: rtl/hex_display_pkg.sv
// Shared types and constants for the 32-bit word to six-digit 7-segment display path.
package hex_display_pkg;

  typedef enum logic [1:0] {IDLE, CONVERT, UPDATE} state_e;

  localparam int          BCD_W    = 40;
  localparam logic [4:0]  CNT_LAST = 5'd31;

  // Active-low segment patterns {g,f,e,d,c,b,a}, indexed by nibble value.
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [15:0][6:0] SEG_LUT = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  function automatic logic [6:0] seg7(input logic [3:0] nibble, input logic active_low);
    return active_low ? SEG_LUT[nibble] : ~SEG_LUT[nibble];
  endfunction

  function automatic logic [6:0] seg_blank(input logic active_low);
    return active_low ? SEG_BLANK : ~SEG_BLANK;
  endfunction

endpackage

// File: rtl/bin_to_bcd_serial.sv
// Serial double-dabble converter: 32-bit binary to 10 BCD digits, one bit per clock.
module bin_to_bcd_serial
  import hex_display_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      bin,
  output logic             done,
  output logic [BCD_W-1:0] bcd
);

  logic [31:0]      bin_q;
  logic [BCD_W-1:0] bcd_q;
  logic [BCD_W-1:0] bcd_adj;
  logic [4:0]       cnt_q;
  logic             run_q;

  genvar gi;
  generate
    for (gi = 0; gi < BCD_W / 4; gi++) begin : g_adj
      assign bcd_adj[gi*4 +: 4] = (bcd_q[gi*4 +: 4] >= 4'd5) ? bcd_q[gi*4 +: 4] + 4'd3
                                                             : bcd_q[gi*4 +: 4];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      bin_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else if (start) begin
      bin_q <= bin;
      bcd_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b1;
    end else if (run_q) begin
      {bcd_q, bin_q} <= {bcd_adj[BCD_W-2:0], bin_q, 1'b0};
      cnt_q          <= cnt_q + 5'd1;
      if (cnt_q == CNT_LAST) begin
        run_q <= 1'b0;
      end
    end
  end

  // High during the final shift; bcd holds the finished result from the next cycle.
  assign done = run_q && (cnt_q == CNT_LAST);
  assign bcd  = bcd_q;

endmodule

// File: rtl/hex_word_display.sv
// Displays a handshaked 32-bit word on HEX5..HEX0 as hex (low 24 bits) or unsigned decimal.
module hex_word_display
  import hex_display_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter bit BLANK_LEADING  = 1'b1,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_mode,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              busy,
  output logic              overflow,
  output logic [6:0]        hex0,
  output logic [6:0]        hex1,
  output logic [6:0]        hex2,
  output logic [6:0]        hex3,
  output logic [6:0]        hex4,
  output logic [6:0]        hex5
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] word_q;
  logic              mode_q;
  logic              accept;
  logic              conv_done;
  logic [BCD_W-1:0]  bcd;
  logic [3:0]        digit [6];
  logic [5:0]        digit_nz;
  logic [5:0]        lit;
  logic [6:0]        seg_d [6];
  logic [6:0]        seg_q [6];
  logic              ovf_d, ovf_q;

  assign in_ready = (state_q == IDLE);
  assign busy     = ~in_ready;
  assign accept   = in_valid && in_ready;

  bin_to_bcd_serial u_bcd (
    .clk   (clk),
    .reset (reset),
    .start (accept && in_mode),
    .bin   (in_data[31:0]),
    .done  (conv_done),
    .bcd   (bcd)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = in_mode ? CONVERT : UPDATE;
      CONVERT: if (conv_done) state_d = UPDATE;
      UPDATE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A digit stays lit if it or any more significant displayed digit is nonzero.
  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_digit
      assign digit[gi]    = mode_q ? bcd[gi*4 +: 4] : word_q[gi*4 +: 4];
      assign digit_nz[gi] = |digit[gi];
      assign lit[gi]      = (gi == 0) || !BLANK_LEADING || (|digit_nz[5:gi]);
      assign seg_d[gi]    = lit[gi] ? seg7(digit[gi], SEG_ACTIVE_LOW) : seg_blank(SEG_ACTIVE_LOW);
    end
  endgenerate

  assign ovf_d = mode_q ? (|bcd[BCD_W-1:24]) : (|word_q[31:24]);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      word_q  <= '0;
      mode_q  <= 1'b0;
      ovf_q   <= 1'b0;
      for (int i = 0; i < 6; i++) begin
        seg_q[i] <= seg_blank(SEG_ACTIVE_LOW);
      end
    end else begin
      state_q <= state_d;
      if (accept) begin
        word_q <= in_data;
        mode_q <= in_mode;
      end
      if (state_q == UPDATE) begin
        seg_q <= seg_d;
        ovf_q <= ovf_d;
      end
    end
  end

  assign overflow = ovf_q;
  assign hex0     = seg_q[0];
  assign hex1     = seg_q[1];
  assign hex2     = seg_q[2];
  assign hex3     = seg_q[3];
  assign hex4     = seg_q[4];
  assign hex5     = seg_q[5];

endmodule

// File: tb/tb_hex_word_display.sv
// Self-checking bench for hex_word_display: scenario tasks plus a latency-aware scoreboard.
module tb_hex_word_display;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] in_data = '0;
  logic        in_mode = 1'b0;
  logic        in_valid = 1'b0;

  logic       in_ready, busy, overflow;
  logic [6:0] hex0, hex1, hex2, hex3, hex4, hex5;
  logic       in_ready_nb, busy_nb, overflow_nb;
  logic [6:0] nb0, nb1, nb2, nb3, nb4, nb5;

  logic [42:0] obs, obs_nb;
  assign obs    = {overflow, hex5, hex4, hex3, hex2, hex1, hex0};
  assign obs_nb = {overflow_nb, nb5, nb4, nb3, nb2, nb1, nb0};

  hex_word_display #(.DATA_W(32), .BLANK_LEADING(1'b1), .SEG_ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_mode(in_mode), .in_valid(in_valid),
    .in_ready(in_ready), .busy(busy), .overflow(overflow),
    .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3), .hex4(hex4), .hex5(hex5)
  );

  hex_word_display #(.DATA_W(32), .BLANK_LEADING(1'b0), .SEG_ACTIVE_LOW(1'b1)) dut_nb (
    .clk(clk), .reset(reset), .in_data(in_data), .in_mode(in_mode), .in_valid(in_valid),
    .in_ready(in_ready_nb), .busy(busy_nb), .overflow(overflow_nb),
    .hex0(nb0), .hex1(nb1), .hex2(nb2), .hex3(nb3), .hex4(nb4), .hex5(nb5)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always @(posedge clk) cyc++;

  typedef struct {
    logic [42:0] exp;
    int          due;
    logic [31:0] data;
    logic        mode;
  } sb_t;
  sb_t sb[$];

  function automatic logic [6:0] lut(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
      4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
      4'h8: return 7'h00; 4'h9: return 7'h10; 4'hA: return 7'h08; 4'hB: return 7'h03;
      4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06; default: return 7'h0E;
    endcase
  endfunction

  // Returns {overflow, hex5..hex0} for a word, computed arithmetically.
  function automatic logic [42:0] model(input logic [31:0] d, input logic m, input bit bl);
    logic [3:0]  dig [6];
    logic [31:0] v;
    logic [42:0] r;
    bit          lit;
    v = d;
    for (int i = 0; i < 6; i++) begin
      if (m) begin
        dig[i] = 4'(v % 10);
        v      = v / 10;
      end else begin
        dig[i] = d[4*i +: 4];
      end
    end
    r[42] = m ? (d > 32'd999999) : (d[31:24] != 8'd0);
    lit = 1'b0;
    for (int i = 5; i >= 0; i--) begin
      if (dig[i] != 4'd0 || i == 0 || !bl) lit = 1'b1;
      r[7*i +: 7] = lit ? lut(dig[i]) : 7'h7F;
    end
    return r;
  endfunction

  // Outputs written at edge E+1 (hex) / E+33 (decimal) are sampled on the following negedge.
  always @(negedge clk) begin
    sb_t e;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      checks++;
      if (obs !== e.exp) begin
        errors++;
        $display("FAIL scoreboard word=%h mode=%0d cyc=%0d: got %h expected %h",
                 e.data, e.mode, cyc, obs, e.exp);
      end else begin
        $display("txn word=%h mode=%0d display=%h", e.data, e.mode, obs);
      end
    end
    if (reset) begin
      sb.delete();
    end else if (in_valid && in_ready) begin
      sb.push_back('{model(in_data, in_mode, 1'b1), cyc + (in_mode ? 34 : 2), in_data, in_mode});
    end
  end

  task automatic send(input logic [31:0] d, input logic m, output int e);
    @(posedge clk); #1;
    in_data = d; in_mode = m; in_valid = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_ready_timeout: in_ready=%b required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    e = cyc;
  endtask

  task automatic wait_cyc(input int t);
    do @(negedge clk); while (cyc < t);
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks++;
    if (obs !== {1'b0, {6{7'h7F}}}) begin
      errors++; $display("FAIL reset_display: got %h required %h", obs, {1'b0, {6{7'h7F}}});
    end
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_handshake: ready=%b busy=%b required 1 0", in_ready, busy);
    end
  endtask

  task automatic test_hex();
    int e;
    send(32'h00123ABC, 1'b0, e);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b1 || obs !== {1'b0, {6{7'h7F}}}) begin
      errors++; $display("FAIL hex_in_flight: ready=%b busy=%b disp=%h", in_ready, busy, obs);
    end
    wait_cyc(e + 1);
    checks++;
    if (obs !== {1'b0, 7'h79, 7'h24, 7'h30, 7'h08, 7'h03, 7'h46} || in_ready !== 1'b1) begin
      errors++; $display("FAIL hex_123ABC: got %h ready=%b required %h", obs, in_ready,
                         {1'b0, 7'h79, 7'h24, 7'h30, 7'h08, 7'h03, 7'h46});
    end
    send(32'h0000000F, 1'b0, e);
    wait_cyc(e + 1);
    checks++;
    if (obs !== {1'b0, {5{7'h7F}}, 7'h0E}) begin
      errors++; $display("FAIL hex_F: got %h required %h", obs, {1'b0, {5{7'h7F}}, 7'h0E});
    end
  endtask

  task automatic test_decimal();
    int e;
    send(32'd999999, 1'b1, e);
    wait_cyc(e + 32);
    checks++;
    if (obs !== {1'b0, {5{7'h7F}}, 7'h0E} || in_ready !== 1'b0) begin
      errors++; $display("FAIL dec_early: got %h ready=%b required old display, ready 0", obs, in_ready);
    end
    wait_cyc(e + 33);
    checks++;
    if (obs !== {1'b0, {6{7'h10}}} || in_ready !== 1'b1) begin
      errors++; $display("FAIL dec_999999: got %h ready=%b required %h", obs, in_ready, {1'b0, {6{7'h10}}});
    end
    send(32'd1000000, 1'b1, e);
    wait_cyc(e + 33);
    checks++;
    if (obs !== {1'b1, {5{7'h7F}}, 7'h40}) begin
      errors++; $display("FAIL dec_1000000: got %h required %h", obs, {1'b1, {5{7'h7F}}, 7'h40});
    end
  endtask

  task automatic test_decimal_max();
    int e;
    int n;
    send(32'hFFFFFFFF, 1'b1, e);
    n = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (in_ready) break;
      n++;
    end
    checks++;
    if (n != 33) begin
      errors++; $display("FAIL dec_ready_low: got %0d cycles required 33", n);
    end
    checks++;
    if (obs !== {1'b1, 7'h10, 7'h02, 7'h78, 7'h24, 7'h10, 7'h12}) begin
      errors++; $display("FAIL dec_max: got %h required %h", obs,
                         {1'b1, 7'h10, 7'h02, 7'h78, 7'h24, 7'h10, 7'h12});
    end
  endtask

  task automatic test_ignore_and_reset();
    int e;
    send(32'd12345, 1'b1, e);
    wait_cyc(e + 3);
    @(posedge clk); #1;
    in_data = 32'h00ABCDEF; in_mode = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_cyc(e + 33);
    checks++;
    if (obs !== {1'b0, 7'h7F, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12} || in_ready !== 1'b1) begin
      errors++; $display("FAIL busy_ignore: got %h ready=%b required %h", obs, in_ready,
                         {1'b0, 7'h7F, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12});
    end
    send(32'd777, 1'b1, e);
    wait_cyc(e + 8);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    checks++;
    if (obs !== {1'b0, {6{7'h7F}}} || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL abort_reset: got %h ready=%b busy=%b required blank, 1, 0", obs, in_ready, busy);
    end
    wait_cyc(e + 35);
    checks++;
    if (obs !== {1'b0, {6{7'h7F}}}) begin
      errors++; $display("FAIL abort_no_partial: got %h required blank", obs);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] words [6] = '{32'h00ABCDEF, 32'd54321, 32'h01000000, 32'd0, 32'h00000010, 32'd4000000000};
    logic        modes [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    int e, prev_e;
    logic prev_m;
    prev_e = 0; prev_m = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_data = words[i]; in_mode = modes[i];
      for (int n = 0; n < 100; n++) begin
        @(negedge clk);
        if (in_ready) break;
      end
      @(posedge clk); #1;
      e = cyc;
      if (i > 0) begin
        checks++;
        if (e - prev_e != (prev_m ? 34 : 2)) begin
          errors++; $display("FAIL b2b_spacing word %0d: got %0d clocks required %0d",
                             i, e - prev_e, prev_m ? 34 : 2);
        end
      end
      prev_e = e; prev_m = modes[i];
    end
    in_valid = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (sb.size() == 0) break;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL b2b_drain: %0d results outstanding, required 0", sb.size());
    end
    send(32'h00000001, 1'b0, e);
    wait_cyc(e + 1);
    checks++;
    if (obs_nb !== {1'b0, {5{7'h40}}, 7'h79}) begin
      errors++; $display("FAIL noblank_1: got %h required %h", obs_nb, {1'b0, {5{7'h40}}, 7'h79});
    end
    checks++;
    if (obs !== {1'b0, {5{7'h7F}}, 7'h79}) begin
      errors++; $display("FAIL blank_1: got %h required %h", obs, {1'b0, {5{7'h7F}}, 7'h79});
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_hex();
    test_decimal();
    test_decimal_max();
    test_ignore_and_reset();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
